stage_sequencer: RTL

// - Parametrised multi-cycle instruction sequencer; generalises the fixed fetch/decode/execute/mem/writeback FSM.
// - Supports N stages and per-instruction stage skipping.
// - Stages flagged in AUTO_MASK complete in one cycle with no finish input.
// - Adds flush, a per-stage watchdog timeout with halt, and a retired-instruction counter.
// - Sits between decode logic (drives skip_mask) and the IFU/EXU/MEMU/WB stage units (consume stage_valid, return stage_finish).

---
 rtl/stage_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multi-stage instruction sequencer with per-instruction stage skip, flush, watchdog halt and retire count.
// Define STAGE_SEQ_PERF_CNT_EN to add per-stage active-cycle counters on stage_cycles_o.
module stage_sequencer #(
  parameter int unsigned            NUM_STAGES = 5,
  parameter logic [NUM_STAGES-1:0]  AUTO_MASK  = NUM_STAGES'(5'b10100),
  parameter int unsigned            TIMEOUT    = 1024,
  parameter int unsigned            CNT_W      = 64,
  localparam int unsigned           STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_en_i,
  input  logic                    flush_i,
  input  logic [NUM_STAGES-1:0]   skip_mask_i,
  input  logic [NUM_STAGES-1:0]   stage_finish_i,
  output logic [NUM_STAGES-1:0]   stage_valid_o,
  output logic [NUM_STAGES-1:0]   stage_active_o,
  output logic [STAGE_W-1:0]      cur_stage_o,
  output logic                    retire_o,
  output logic [CNT_W-1:0]        instret_o,
  output logic                    timeout_o,
  output logic                    halted_o
`ifdef STAGE_SEQ_PERF_CNT_EN
  ,
  output logic [NUM_STAGES*CNT_W-1:0] stage_cycles_o
`endif
);

  localparam int unsigned WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WD_LIMIT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [STAGE_W-1:0]     stage_q, stage_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [NUM_STAGES-1:0]  valid_q, valid_d;
  logic [NUM_STAGES-1:0]  active_q, active_d;
  logic                   retire_q, retire_d;
  logic [CNT_W-1:0]       instret_q, instret_d;
  logic                   timeout_q, timeout_d;
  logic                   halted_q, halted_d;

  logic                   done;
  logic                   expire;
  logic                   found;
  logic                   enter;
  logic [STAGE_W-1:0]     nxt_stage;

  // Done, watchdog expiry and the next unskipped stage for the current stage
  always_comb begin
    done      = |((AUTO_MASK | stage_finish_i) & active_q);
    expire    = (TIMEOUT != 0) && (wd_q == WD_W'(WD_LIMIT)) && !done;
    found     = 1'b0;
    nxt_stage = '0;
    for (int j = int'(NUM_STAGES) - 1; j > 0; j--) begin
      if ((j > int'(stage_q)) && !skip_mask_i[j]) begin
        found     = 1'b1;
        nxt_stage = STAGE_W'(j);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    wd_d      = wd_q;
    retire_d  = 1'b0;
    instret_d = instret_q;
    timeout_d = timeout_q;
    enter     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_en_i) begin
          state_d = ST_RUN;
          stage_d = '0;
          wd_d    = '0;
          enter   = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          stage_d = '0;
          wd_d    = '0;
          enter   = 1'b1;
        end else if (done) begin
          wd_d = '0;
          if (found) begin
            stage_d = nxt_stage;
            enter   = 1'b1;
          end else begin
            retire_d  = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            stage_d   = '0;
            if (start_en_i) begin
              enter = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (expire) begin
          state_d   = ST_HALT;
          stage_d   = '0;
          wd_d      = '0;
          timeout_d = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
        stage_d = '0;
        wd_d    = '0;
      end
    endcase

    halted_d = (state_d == ST_HALT);
    valid_d  = '0;
    active_d = '0;
    for (int j = 0; j < int'(NUM_STAGES); j++) begin
      active_d[j] = (state_d == ST_RUN) && (stage_d == STAGE_W'(j));
      valid_d[j]  = enter && (stage_d == STAGE_W'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      wd_q      <= '0;
      valid_q   <= '0;
      active_q  <= '0;
      retire_q  <= 1'b0;
      instret_q <= '0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      wd_q      <= wd_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
      timeout_q <= timeout_d;
      halted_q  <= halted_d;
    end
  end

  assign stage_valid_o  = valid_q;
  assign stage_active_o = active_q;
  assign cur_stage_o    = stage_q;
  assign retire_o       = retire_q;
  assign instret_o      = instret_q;
  assign timeout_o      = timeout_q;
  assign halted_o       = halted_q;

`ifdef STAGE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q [NUM_STAGES];

  // Per-stage residency counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        cyc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        if (active_q[k]) begin
          cyc_q[k] <= cyc_q[k] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_perf
    assign stage_cycles_o[k*CNT_W +: CNT_W] = cyc_q[k];
  end
`endif

endmodule
